// File: rtl/lector_sensor_temp.sv
// SPI-style reader for a digital temperature sensor: clocks out 16-bit frames,
// validates the 5-bit tag and publishes the signed 11-bit reading.
module lector_sensor_temp #(
    parameter int         DIV       = 4,
    parameter int         PERIODO   = 1000,
    parameter logic [4:0] ID_SENSOR = 5'b00011
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               habilitar,
    input  logic               miso,
    output logic               sck,
    output logic               cs_n,
    output logic signed [10:0] temp_salida,
    output logic               temp_valida,
    output logic               error_trama,
    output logic [7:0]         contador_errores,
    output logic               ocupado
);

    localparam logic [2:0] REPOSO        = 3'd0;
    localparam logic [2:0] SELECCION     = 3'd1;
    localparam logic [2:0] TRANSFERENCIA = 3'd2;
    localparam logic [2:0] CIERRE        = 3'd3;
    localparam logic [2:0] ESPERA        = 3'd4;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [15:0] PER_M1 = 16'(PERIODO - 1);

    logic [2:0]         estado_q, estado_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               fase_q, fase_d;
    logic [3:0]         bit_q, bit_d;
    logic [15:0]        trama_q, trama_d;
    logic               miso_s1_q, miso_s2_q;
    logic               sck_q, cs_n_q, valida_q, error_q, ocupado_q;
    logic signed [10:0] temp_q;
    logic [7:0]         errores_q;
    logic               tag_ok;

    assign tag_ok = (trama_q[4:0] == ID_SENSOR);

    // cnt_q is shared: sck half-period timer during the frame, gap timer in ESPERA
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        fase_d   = fase_q;
        bit_d    = bit_q;
        trama_d  = trama_q;
        case (estado_q)
            REPOSO: begin
                if (habilitar) begin
                    estado_d = SELECCION;
                    cnt_d    = '0;
                end
            end
            SELECCION: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d    = '0;
                    fase_d   = 1'b0;
                    bit_d    = '0;
                    estado_d = TRANSFERENCIA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TRANSFERENCIA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d  = '0;
                    fase_d = ~fase_q;
                    if (fase_q) begin
                        trama_d = {trama_q[14:0], miso_s2_q};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15)
                            estado_d = CIERRE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CIERRE: begin
                // CIERRE is the first cycle of the inter-frame gap
                if (PERIODO == 1) begin
                    cnt_d    = '0;
                    estado_d = habilitar ? SELECCION : REPOSO;
                end else begin
                    cnt_d    = 16'd1;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (cnt_q == PER_M1) begin
                    cnt_d    = '0;
                    estado_d = habilitar ? SELECCION : REPOSO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            fase_q    <= 1'b0;
            bit_q     <= '0;
            trama_q   <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            valida_q  <= 1'b0;
            error_q   <= 1'b0;
            ocupado_q <= 1'b0;
            temp_q    <= '0;
            errores_q <= '0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            fase_q    <= fase_d;
            bit_q     <= bit_d;
            trama_q   <= trama_d;
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
            // pin outputs follow the state one cycle later, keeping them glitch-free
            cs_n_q    <= !(estado_q == SELECCION || estado_q == TRANSFERENCIA);
            sck_q     <= (estado_q == TRANSFERENCIA) && fase_q;
            valida_q  <= (estado_q == CIERRE) && tag_ok;
            error_q   <= (estado_q == CIERRE) && !tag_ok;
            ocupado_q <= (estado_d != REPOSO);
            if (estado_q == CIERRE) begin
                if (tag_ok)
                    temp_q <= $signed(trama_q[15:5]);
                else if (errores_q != 8'hFF)
                    errores_q <= errores_q + 8'd1;
            end
        end
    end

    assign sck              = sck_q;
    assign cs_n             = cs_n_q;
    assign temp_salida      = temp_q;
    assign temp_valida      = valida_q;
    assign error_trama      = error_q;
    assign contador_errores = errores_q;
    assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_lector_sensor_temp.sv
// Bench for lector_sensor_temp: sensor model on miso, frame-timeline reference
// model compared every cycle, plus directed literal checks.
module tb_lector_sensor_temp;

    localparam int DIV     = 4;
    localparam int PERIODO = 20;
    localparam int FR      = 33 * DIV;

    logic clk = 1'b0, arst = 1'b0, habilitar = 1'b0, miso = 1'b0;
    logic sck, cs_n, temp_valida, error_trama, ocupado;
    logic signed [10:0] temp_salida;
    logic [7:0] contador_errores;

    lector_sensor_temp #(.DIV(DIV), .PERIODO(PERIODO), .ID_SENSOR(5'b00011)) dut (
        .clk(clk), .arst(arst), .habilitar(habilitar), .miso(miso),
        .sck(sck), .cs_n(cs_n), .temp_salida(temp_salida),
        .temp_valida(temp_valida), .error_trama(error_trama),
        .contador_errores(contador_errores), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int t, input logic [4:0] tag);
        logic [10:0] v;
        v = t[10:0];
        return {v, tag};
    endfunction

    // Sensor: presents MSB on cs_n fall, next bit on each sck fall
    logic [15:0] cola[$];
    logic [15:0] sensor_word = '0;
    int idx = 0;
    always @(negedge cs_n) begin
        if (cola.size() > 0) sensor_word = cola.pop_front();
        else sensor_word = 16'h0000;
        idx  = 15;
        miso = sensor_word[15];
    end
    always @(negedge sck) begin
        if (idx > 0) begin
            idx--;
            miso = sensor_word[idx];
        end
    end

    // Reference model: rel is the cycle offset from the first cs_n-low cycle of the frame
    int rel = 0;
    bit act = 0, idle = 1;
    logic signed [10:0] e_temp;
    logic [7:0] e_errs;
    logic e_val, e_err, e_cs_n, e_sck, e_ocup;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            act = 0; idle = 1; rel = 0;
            e_temp = '0; e_errs = '0; e_val = 0; e_err = 0;
        end else begin
            if (act) rel++;
            if (idle) begin
                if (habilitar) begin act = 1; idle = 0; rel = -1; end
            end else if (rel == FR + PERIODO - 1) begin
                if (habilitar) rel = -1;
                else idle = 1;
            end
            e_val = 0; e_err = 0;
            if (act && rel == FR) begin
                if (sensor_word[4:0] == 5'b00011) begin
                    e_temp = sensor_word[15:5];
                    e_val  = 1;
                end else begin
                    e_err = 1;
                    if (e_errs != 8'd255) e_errs++;
                end
            end
        end
        e_cs_n = !(act && rel >= 0 && rel < FR);
        e_sck  = act && rel >= DIV && rel < FR && ((rel - DIV) % (2 * DIV)) >= DIV;
        e_ocup = act && rel >= -1 && rel <= FR + PERIODO - 2;
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cs_n", cs_n, e_cs_n);
            chk("sck", sck, e_sck);
            chk("ocupado", ocupado, e_ocup);
            chk("temp_valida", temp_valida, e_val);
            chk("error_trama", error_trama, e_err);
            chk("temp_salida", temp_salida, e_temp);
            chk("contador_errores", contador_errores, e_errs);
        end
    end

    // Measurements for the literal checks
    int cyc_n = 0, low_run = 0, last_low = 0, high_run = 0, last_gap = 0;
    int sck_rises = 0, vld_cnt = 0, err_pulses = 0, last_vld_cyc = -1, vld_spacing = 0;
    logic sck_prev = 1'b0, cs_prev = 1'b1;
    always @(negedge clk) begin
        cyc_n++;
        if (cs_n === 1'b0) begin
            if (cs_prev) begin last_gap = high_run; low_run = 1; end
            else low_run++;
            high_run = 0;
        end else begin
            if (!cs_prev) begin last_low = low_run; high_run = 1; end
            else high_run++;
        end
        if (sck === 1'b1 && !sck_prev) sck_rises++;
        if (temp_valida === 1'b1) begin
            vld_cnt++;
            if (last_vld_cyc >= 0) vld_spacing = cyc_n - last_vld_cyc;
            last_vld_cyc = cyc_n;
        end
        if (error_trama === 1'b1) err_pulses++;
        sck_prev = (sck === 1'b1);
        cs_prev  = (cs_n !== 1'b0);
    end

    task automatic clr_meas();
        sck_rises = 0; vld_cnt = 0; err_pulses = 0; last_vld_cyc = -1; vld_spacing = 0;
    endtask

    task automatic wait_idle(input int lim);
        bit done;
        done = 0;
        for (int i = 0; i < lim && !done; i++) begin
            @(negedge clk);
            if (ocupado === 1'b0) done = 1;
        end
        if (!done) chk("wait_idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic frame_single(input logic [15:0] w);
        cola.push_back(w);
        clr_meas();
        habilitar = 1;
        @(posedge clk); #1;
        habilitar = 0;
        wait_idle(400);
    endtask

    int extremos[3] = '{-40, -1024, 1023};

    initial begin
        bit done;
        #2 arst = 1; chk_on = 1;
        repeat (20) begin
            @(posedge clk); #1;
            habilitar = 1'($urandom_range(0, 1));
            miso      = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_temp", temp_salida, 0);
        chk("rst_errs", contador_errores, 0);
        @(posedge clk); #1;
        arst = 0; habilitar = 0;
        repeat (3) @(posedge clk); #1;

        // nominal read
        frame_single(mk(100, 5'b00011));
        chk("nom_cs_low_len", last_low, 132);
        chk("nom_sck_rises", sck_rises, 16);
        chk("nom_vld_pulses", vld_cnt, 1);
        chk("nom_temp", temp_salida, 100);

        // signed extremes
        foreach (extremos[i]) begin
            frame_single(mk(extremos[i], 5'b00011));
            chk("ext_temp", temp_salida, extremos[i]);
            chk("ext_vld_pulses", vld_cnt, 1);
        end

        // good then bad tag
        frame_single(mk(100, 5'b00011));
        frame_single(mk(55, 5'b10101));
        chk("bad_temp_held", temp_salida, 100);
        chk("bad_errs", contador_errores, 1);
        chk("bad_err_pulses", err_pulses, 1);
        chk("bad_no_vld", vld_cnt, 0);

        // habilitar dropped mid-frame
        cola.push_back(mk(-7, 5'b00011));
        clr_meas();
        habilitar = 1;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sck_rises >= 5) done = 1;
        end
        if (!done) chk("drop_wait_timeout", 0, 1);
        @(posedge clk); #1;
        habilitar = 0;
        wait_idle(400);
        chk("drop_temp", temp_salida, -7);
        chk("drop_vld_pulses", vld_cnt, 1);
        chk("drop_sck_rises", sck_rises, 16);

        // reset in the middle of bit 8
        cola.push_back(mk(77, 5'b00011));
        clr_meas();
        habilitar = 1;
        @(posedge clk); #1;
        habilitar = 0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sck_rises >= 8) done = 1;
        end
        if (!done) chk("rst_mid_wait_timeout", 0, 1);
        @(posedge clk); #1;
        arst = 1;
        #1;
        chk("rst_mid_cs_n", cs_n, 1);
        chk("rst_mid_sck", sck, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_vld", vld_cnt, 0);
        chk("rst_mid_no_err", err_pulses, 0);
        chk("rst_mid_temp", temp_salida, 0);
        @(posedge clk); #1;
        arst = 0;
        repeat (2) @(posedge clk); #1;

        // continuous mode, three frames
        cola.push_back(mk(10, 5'b00011));
        cola.push_back(mk(20, 5'b00011));
        cola.push_back(mk(30, 5'b00011));
        clr_meas();
        habilitar = 1;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (vld_cnt >= 2) done = 1;
        end
        if (!done) chk("cont_wait_timeout", 0, 1);
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0) done = 1;
        end
        if (!done) chk("cont_cs_timeout", 0, 1);
        @(posedge clk); #1;
        habilitar = 0;
        wait_idle(400);
        chk("cont_vld_pulses", vld_cnt, 3);
        chk("cont_vld_spacing", vld_spacing, FR + PERIODO);
        chk("cont_gap", last_gap, PERIODO);
        chk("cont_temp", temp_salida, 30);

        // error counter saturation
        for (int i = 0; i < 300; i++) cola.push_back(mk(5, 5'b10101));
        clr_meas();
        habilitar = 1;
        done = 0;
        for (int i = 0; i < 50000 && !done; i++) begin
            @(negedge clk);
            if (err_pulses >= 300) done = 1;
        end
        if (!done) chk("sat_wait_timeout", 0, 1);
        @(posedge clk); #1;
        habilitar = 0;
        wait_idle(400);
        chk("sat_errs", contador_errores, 255);
        chk("sat_temp_held", temp_salida, 30);
        chk("sat_no_vld", vld_cnt, 0);

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
